// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write bank and its read mux:
// bank geometry and the clear-sequencer state encoding.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_wr_decoder.sv
// Write-address decoder: turns a 5-bit register index into a one-hot write
// enable, forced to all-zero when no write is firing.
module reg_wr_decoder
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] we
);

  always_comb begin
    we = '0;
    if (en) we[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32-entry register file with a one-entry-per-cycle bulk clear.
// Build option: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_write_bank
  import regfile_pkg::*;
#(
  parameter int N = 4
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic                  clr_req,
  output logic                  busy,
  output logic [NUM_REGS*N-1:0] q
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  state_t                state, state_next;
  logic [ADDR_W-1:0]     ptr;
  logic                  wr_fire;
  logic [NUM_REGS-1:0]   wr_we;
  logic [NUM_REGS-1:0]   clr_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR:   if (ptr == ADDR_W'(NUM_REGS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state == IDLE);
    busy     = (state == CLEAR);
  end

  // ptr sits at 0 throughout IDLE so a clear always starts from register 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ptr <= '0;
    else if (state == CLEAR)  ptr <= ptr + 1'b1;
    else                      ptr <= '0;
  end

  assign wr_fire = wr_valid & wr_ready;

  reg_wr_decoder u_dec (
    .en   (wr_fire),
    .addr (wr_addr),
    .we   (wr_we)
  );

  always_comb begin
    clr_we = '0;
    if (state == CLEAR) clr_we[ptr] = 1'b1;
  end

  // Writes only fire in IDLE and clears only in CLEAR, so the two never collide
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    if (ZERO_REG && k == 0) begin : g_zero
      assign q[k*N +: N] = '0;
    end else begin : g_store
      logic [N-1:0] r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r <= '0;
        else if (clr_we[k]) r <= '0;
        else if (wr_we[k])  r <= wr_data;
      end
      assign q[k*N +: N] = r;
    end
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank: table-driven writes plus hand-written
// clear, collision and reset-mid-clear sequences.
module tb_regfile_write_bank;
  import regfile_pkg::*;

  localparam int N  = 4;
  localparam int QW = NUM_REGS * N;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;
  logic              clr_req;
  logic              busy;
  logic [QW-1:0]     q;

  regfile_write_bank #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .q        (q)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  logic [N-1:0] mdl [NUM_REGS];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      data;
    logic [N-1:0]      exp;
  } wr_vec_t;

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [QW-1:0] model_q();
    logic [QW-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*N +: N] = mdl[i];
    return v;
  endfunction

  function automatic logic [N-1:0] slot(input logic [QW-1:0] v, input int k);
    return v[k*N +: N];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
  endtask

  wr_vec_t vecs [6];
  int cyc;

  initial begin
    vecs[0] = '{addr: 5'd5,  data: 4'hA, exp: 4'hA};
    vecs[1] = '{addr: 5'd31, data: 4'hF, exp: 4'hF};
    vecs[2] = '{addr: 5'd0,  data: 4'h3, exp: ZR ? 4'h0 : 4'h3};
    vecs[3] = '{addr: 5'd7,  data: 4'h9, exp: 4'h9};
    vecs[4] = '{addr: 5'd12, data: 4'h5, exp: 4'h5};
    vecs[5] = '{addr: 5'd5,  data: 4'h1, exp: 4'h1};

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    clear_model();
    #1;
    check("reset_q", q, '0);
    check("reset_ready", QW'(wr_ready), QW'(1));
    check("reset_busy", QW'(busy), QW'(0));
    step(); step();
    rst_n = 1'b1;
    step();

    // Back-to-back writes from the table; every write checked against the whole bank
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      step();
      mdl[vecs[i].addr] = vecs[i].exp;
      check($sformatf("write%0d_slot", i), QW'(slot(q, vecs[i].addr)), QW'(vecs[i].exp));
      check($sformatf("write%0d_bank", i), q, model_q());
    end
    wr_valid = 1'b0;

    // Fill, then clear: registers zeroed in order 0..31 over exactly 32 cycles
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = N'((i % 15) + 1);
      step();
      mdl[i] = (ZR && i == 0) ? '0 : N'((i % 15) + 1);
    end
    wr_valid = 1'b0;
    check("fill_bank", q, model_q());
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < NUM_REGS; c++) begin
      check($sformatf("clear_c%0d_busy", c), QW'({busy, wr_ready}), QW'(2'b10));
      check($sformatf("clear_c%0d_bank", c), q, model_q());
      step();
      mdl[c] = '0;
    end
    check("clear_done_ctl", QW'({busy, wr_ready}), QW'(2'b01));
    check("clear_done_bank", q, '0);

    // Collision: write and clear request on the same edge
    clear_model();
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 4'h9; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("coll_q7", QW'(slot(q, 7)), QW'(4'h9));
    check("coll_busy", QW'(busy), QW'(1));
    wr_addr = 5'd20; wr_data = 4'h6;
    cyc = 0;
    while (!wr_ready && cyc < 40) begin
      cyc++;
      clr_req = (cyc == 10);
      step();
      if (cyc == 7) check("coll_q7_held", QW'(slot(q, 7)), QW'(4'h9));
      if (cyc == 8) check("coll_q7_zeroed", QW'(slot(q, 7)), QW'(0));
      if (cyc == 20) check("coll_stall_q20", QW'(slot(q, 20)), QW'(0));
    end
    clr_req = 1'b0;
    check("coll_clear_len", QW'(cyc), QW'(32));
    step();
    wr_valid = 1'b0;
    check("coll_held_write", QW'(slot(q, 20)), QW'(4'h6));
    check("coll_idle", QW'({busy, wr_ready}), QW'(2'b01));

    // Reset in the middle of a clear
    wr_valid = 1'b1; wr_addr = 5'd25; wr_data = 4'hC;
    step();
    wr_valid = 1'b0;
    check("pre_rst_q25", QW'(slot(q, 25)), QW'(4'hC));
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("midclr_busy", QW'(busy), QW'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_q", q, '0);
    check("midrst_ctl", QW'({busy, wr_ready}), QW'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ctl", QW'({busy, wr_ready}), QW'(2'b01));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
